routermerge_sync_n: RTL
=======================

// Module: routermerge_sync_n
// PURPOSE
// - Parametrised synchronous successor of the 5-input router merge: NUM_IN data inputs, one control channel.
// - Each control token names the input whose data goes to the single output.
// - Adds a packet-lock mode, drop/flag of illegal control tokens and a DEPTH-entry output FIFO.
// - Sits at a router output port, between the per-direction input buffers and the link driver.
// PARAMETERS
// - NUM_IN   default 5  : number of data inputs, 2..16
// - W        default 11 : data width; bit W-1 is the tail flag in packet mode
// - DEPTH    default 2  : output FIFO entries, power of 2, >=2
// - PKT_MODE default 0  : 0 = one control token per flit; 1 = one control token per packet (lock until tail)
// - SEL_W    default $clog2(NUM_IN) : control width (derived, do not override)
// PORTS
// - CLK         in   1          : clock, rising edge
// - RESET       in   1          : asynchronous, active-high reset
// - in_data     in   NUM_IN*W   : input i occupies bits [i*W +: W]
// - in_valid    in   NUM_IN     : per-input valid
// - in_ready    out  NUM_IN     : per-input ready
// - ctrl_data   in   SEL_W      : selected input index
// - ctrl_valid  in   1          : control valid
// - ctrl_ready  out  1          : control consumed
// - out_data    out  W          : FIFO head data
// - out_src     out  SEL_W      : source index of the head entry
// - out_valid   out  1          : FIFO not empty
// - out_ready   in   1          : downstream accept
// - ctrl_err    out  1          : sticky, illegal control index seen
// BEHAVIOUR
// - Handshakes: a transfer occurs on a rising CLK edge with valid&&ready.
//   - Valid must not depend on ready.
//   - Valid and data hold until the transfer.
// - Reset (any time, asynchronous): FIFO emptied, FSM to IDLE, ctrl_err=0.
//   - All outputs 0 while RESET=1: out_valid, in_ready, ctrl_ready, out_data, out_src.
//   - In-flight beats are discarded.
// - full = (count==DEPTH). No push when full, even if a pop occurs in the same cycle.
// - Pop when out_valid&&out_ready. Push and pop may coincide when not full.
// - Latency: a beat accepted at edge t is visible on out_data at t+1. Throughput is 1 beat/cycle.
// - Ordering is strict: the FIFO outputs beats in acceptance order.
// - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
// - FSM states IDLE and LOCK; LOCK exists only when PKT_MODE=1. sel is the latched index.
// - IDLE, ctrl_valid, ctrl_data>=NUM_IN:
//   - ctrl_ready=1, the token is dropped and ctrl_err is set.
//   - No data moves.
// - IDLE, ctrl_valid, legal index s:
//   - fire = in_valid[s] && !full.
//   - in_ready[s] = ctrl_ready = fire, combinationally. All other in_ready are 0.
//   - PKT_MODE=0: stay in IDLE.
//   - PKT_MODE=1: if the beat is not a tail (bit W-1 = 0), latch sel=s and go to LOCK. A tail beat (single-flit packet) stays in IDLE.
// - LOCK:
//   - in_ready[sel] = !full. ctrl_ready=0.
//   - A beat with tail=1 returns the FSM to IDLE.
//   - Other inputs stall for the whole packet.
// - A combinational path from in_valid/ctrl_valid to in_ready/ctrl_ready is permitted. There is no path from out_ready to any in_ready.
// CONFIGURATION
// - Macro ROUTERMERGE_ERRCNT_EN.
// - Defined:
//   - Adds output err_cnt[7:0], a saturating count of dropped illegal control tokens.
//   - err_cnt stops at 255 and resets to 0.
//   - ctrl_err behaves as without the macro.
// - Undefined: no err_cnt port, no counter logic.
// TESTING
// - T1 PKT_MODE=0, DEPTH=2, out_ready=1:
//   - Stimulus: ctrl tokens 0,1,2,3,4, every input valid with data=index+1.
//   - Required: out_data 1,2,3,4,5 on consecutive cycles, each 1 cycle after its accept; out_src matches.
// - T2 out_ready=0, 3 accepted tokens:
//   - Required: the first 2 beats are accepted; ctrl_ready=0 on the third until the first pop.
//   - Required: no beat is lost or duplicated.
// - T3 ctrl_data=7 with NUM_IN=5:
//   - Required: the token is consumed in 1 cycle, ctrl_err=1, no out_valid.
//   - Required: err_cnt=1 with the macro defined; err_cnt=255 after 300 illegal tokens.
// - T4 PKT_MODE=1, ctrl=2:
//   - Stimulus: input 2 sends 3 flits with tail on the 3rd; input 0 is valid throughout.
//   - Required: in_ready[0]=0 until the tail is accepted; the next ctrl token is accepted only afterwards.
// - T5 RESET pulse while LOCK with FIFO count=2:
//   - Required: out_valid=0 immediately, and after release the FSM is IDLE and requires a fresh ctrl token.
// - T6 random cosim against the CSP gold model:
//   - Stimulus: random ctrl 0..NUM_IN-1, incrementing data per input, random out_ready.
//   - Required: the output sequence matches exactly over 10k beats.

Source files
------------

// File: rtl/routermerge_sync_n_if.sv
// Bus interface for routermerge_sync_n: NUM_IN data inputs, one control channel, one output.
// master = upstream/downstream environment side, slave = the merge block.
interface routermerge_sync_n_if #(
   parameter int unsigned NUM_IN = 5,
   parameter int unsigned W      = 11,
   parameter int unsigned SEL_W  = $clog2(NUM_IN)
);
   logic [NUM_IN*W-1:0] in_data;
   logic [NUM_IN-1:0]   in_valid;
   logic [NUM_IN-1:0]   in_ready;
   logic [SEL_W-1:0]    ctrl_data;
   logic                ctrl_valid;
   logic                ctrl_ready;
   logic [W-1:0]        out_data;
   logic [SEL_W-1:0]    out_src;
   logic                out_valid;
   logic                out_ready;
   logic                ctrl_err;

   modport master (
      output in_data, in_valid, ctrl_data, ctrl_valid, out_ready,
      input  in_ready, ctrl_ready, out_data, out_src, out_valid, ctrl_err
   );

   modport slave (
      input  in_data, in_valid, ctrl_data, ctrl_valid, out_ready,
      output in_ready, ctrl_ready, out_data, out_src, out_valid, ctrl_err
   );
endinterface

// File: rtl/routermerge_sync_n.sv
// Router output-port merge: control tokens pick which of NUM_IN inputs feeds a
// DEPTH-entry output FIFO. PKT_MODE=1 locks the chosen input until a tail flit.
// Illegal control indices are dropped and flagged on sticky ctrl_err.
// Optional: define ROUTERMERGE_ERRCNT_EN to add err_cnt[7:0], a saturating
// count of dropped illegal control tokens.
module routermerge_sync_n #(
   parameter int unsigned NUM_IN   = 5,
   parameter int unsigned W        = 11,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned PKT_MODE = 0,
   parameter int unsigned SEL_W    = $clog2(NUM_IN)
) (
   input  logic                 clk,
   input  logic                 rst,
   routermerge_sync_n_if.slave  bus
`ifdef ROUTERMERGE_ERRCNT_EN
   ,
   output logic [7:0]           err_cnt
`endif
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = SEL_W + W;

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [SEL_W-1:0]  sel, sel_nxt;
   logic [SEL_W-1:0]  idx;
   logic [W-1:0]      cand_data;
   logic              cand_valid;
   logic              illegal;
   logic              full;
   logic              not_empty;
   logic              push;
   logic              pop;
   logic              err_set;
   logic [NUM_IN-1:0] in_ready_c;
   logic              ctrl_ready_c;
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [ENT_W-1:0]  head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;

   assign full      = (count == CNT_W'(DEPTH));
   assign not_empty = (count != '0);
   assign pop       = not_empty && bus.out_ready;
   assign illegal   = (32'(bus.ctrl_data) >= NUM_IN);
   assign idx       = (state == LOCK) ? sel : bus.ctrl_data;

   // Select the candidate input's data/valid (locked input while in LOCK)
   always_comb begin
      cand_data  = '0;
      cand_valid = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (idx == SEL_W'(i)) begin
            cand_data  = bus.in_data[i*W +: W];
            cand_valid = bus.in_valid[i];
         end
      end
   end

   // FSM next-state and handshake decode; readiness never looks at out_ready
   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel;
      in_ready_c   = '0;
      ctrl_ready_c = 1'b0;
      push         = 1'b0;
      err_set      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ctrl_valid) begin
               if (illegal) begin
                  ctrl_ready_c = 1'b1;
                  err_set      = 1'b1;
               end else begin
                  push         = cand_valid && !full;
                  ctrl_ready_c = push;
                  for (int i = 0; i < NUM_IN; i++) begin
                     in_ready_c[i] = push && (idx == SEL_W'(i));
                  end
                  if ((PKT_MODE != 0) && push && !cand_data[W-1]) begin
                     state_nxt = LOCK;
                     sel_nxt   = idx;
                  end
               end
            end
         end
         LOCK: begin
            for (int i = 0; i < NUM_IN; i++) begin
               in_ready_c[i] = !full && (sel == SEL_W'(i));
            end
            push = cand_valid && !full;
            if (push && cand_data[W-1]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ready outputs are forced low while reset is held
   assign bus.in_ready   = rst ? '0 : in_ready_c;
   assign bus.ctrl_ready = rst ? 1'b0 : ctrl_ready_c;

   // FSM state and latched packet source
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sel   <= '0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FIFO storage: source index above data
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {idx, cand_data};
   end

   assign head          = mem[rd_ptr];
   assign bus.out_valid = not_empty;
   assign bus.out_data  = not_empty ? head[W-1:0] : '0;
   assign bus.out_src   = not_empty ? head[ENT_W-1 -: SEL_W] : '0;

   // Sticky illegal-token flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          bus.ctrl_err <= 1'b0;
      else if (err_set) bus.ctrl_err <= 1'b1;
   end

`ifdef ROUTERMERGE_ERRCNT_EN
   // Saturating count of dropped illegal tokens
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            err_cnt <= 8'd0;
      else if (err_set && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end
`endif
endmodule
